// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit_if
//  Brief    : Instruction-memory read bus (req/ack handshake) between the
//             fetch stage and instruction memory.
//  Revision : 1.0  initial release
// ============================================================================
interface instr_fetch_unit_if;
  logic        imem_req;    // read request, held until imem_ack
  logic [31:0] imem_addr;   // word-aligned read address
  logic        imem_ack;    // memory returns data this cycle
  logic [31:0] imem_rdata;  // instruction word, valid with imem_ack

  // Fetch unit side
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  // Instruction memory side
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit
//  Brief    : Fetch stage of the multicycle MIPS core. Owns the PC, reads one
//             word per instruction over a req/ack bus, holds it in the
//             instruction register and hands it downstream with valid/ready.
//             Supports branch/jump redirects and flags misaligned targets.
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  instr_fetch_unit_if.master     imem,
  output logic                   ir_valid_o,
  input  wire logic              ir_ready_i,
  output logic [31:0]            instr_o,
  output logic [5:0]             opcode_o,
  output logic [4:0]             rs_o,
  output logic [4:0]             rt_o,
  output logic [4:0]             rd_o,
  output logic [5:0]             funct_o,
  output logic [15:0]            imm16_o,
  output logic [31:0]            instr_pc_o,
  output logic [31:0]            pc_plus4_o,
  input  wire logic              redirect_valid_i,
  input  wire logic [31:0]       redirect_pc_i,
  output logic                   fetch_fault_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  // The low two PC bits are forced to zero so a bad RESET_PC can never
  // produce a misaligned address.
  localparam logic [31:0] C_RESET_PC = {RESET_PC[31:2], 2'b00};

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;          // redirect captured during an in-flight read
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        fault_pend_q, fault_pend_d; // misaligned target seen, waiting for ack
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        fault_q, fault_d;

  logic        w_misaligned;
  logic [31:0] w_pc_next;

  assign w_misaligned = |redirect_pc_i[1:0];
  assign w_pc_next    = pc_q + 32'd4;   // wraps modulo 2^32

  // State and datapath registers; reset acts immediately without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= C_RESET_PC;
      pend_q       <= 1'b0;
      pend_pc_q    <= 32'd0;
      fault_pend_q <= 1'b0;
      instr_q      <= 32'd0;
      instr_pc_q   <= 32'd0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      pend_pc_q    <= pend_pc_d;
      fault_pend_q <= fault_pend_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      fault_q      <= fault_d;
    end
  end

  // Next-state logic: an issued read is never cancelled, so redirects that
  // arrive while a read is outstanding are parked until the ack returns.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_d       = pend_q;
    pend_pc_d    = pend_pc_q;
    fault_pend_d = fault_pend_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    fault_d      = fault_q;

    unique case (state_q)
      S_FETCH: begin
        if (imem.imem_ack) begin
          if (redirect_valid_i) begin
            // Newest redirect wins over any parked one; returned data dropped.
            pend_d = 1'b0;
            if (w_misaligned) begin
              fault_d = 1'b1;
              state_d = S_FAULT;
            end else if (fault_pend_q) begin
              state_d = S_FAULT;
            end else begin
              pc_d = redirect_pc_i;
            end
          end else if (fault_pend_q) begin
            pend_d  = 1'b0;
            state_d = S_FAULT;
          end else if (pend_q) begin
            pc_d   = pend_pc_q;
            pend_d = 1'b0;
          end else begin
            instr_d    = imem.imem_rdata;
            instr_pc_d = pc_q;
            pc_d       = w_pc_next;
            state_d    = S_HOLD;
          end
        end else if (redirect_valid_i) begin
          if (w_misaligned) begin
            fault_d      = 1'b1;
            fault_pend_d = 1'b1;
          end else begin
            pend_d    = 1'b1;
            pend_pc_d = redirect_pc_i;
          end
        end
      end

      S_HOLD: begin
        // A redirect leaves HOLD whether or not the handshake completes.
        if (redirect_valid_i) begin
          if (w_misaligned) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            pc_d    = redirect_pc_i;
            state_d = S_FETCH;
          end
        end else if (ir_ready_i) begin
          state_d = S_FETCH;
        end
      end

      S_FAULT: begin
        state_d = S_FAULT;
      end

      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  // The request is masked by rst_n so it drops asynchronously and rises in
  // the first cycle after release.
  assign imem.imem_req  = rst_n && (state_q == S_FETCH);
  assign imem.imem_addr = pc_q;

  assign ir_valid_o    = (state_q == S_HOLD);
  assign fetch_fault_o = fault_q;

  // Decoded fields are plain slices of the instruction register.
  assign instr_o    = instr_q;
  assign opcode_o   = instr_q[31:26];
  assign rs_o       = instr_q[25:21];
  assign rt_o       = instr_q[20:16];
  assign rd_o       = instr_q[15:11];
  assign funct_o    = instr_q[5:0];
  assign imm16_o    = instr_q[15:0];
  assign instr_pc_o = instr_pc_q;
  assign pc_plus4_o = instr_pc_q + 32'd4;

endmodule
`default_nettype wire
